// File: rtl/drc_gain_compute.sv
// drc_gain_compute: DRC gain stage (static gain by restoring divide, attack/hold/release smoothing, gain apply + saturate)
// Optional feature macro: MAKEUP_GAIN_EN (adds a Q4.12 makeup-gain stage after the smoothed gain).
// Ports:
//   clk, rst_n (async, active-low)  enable (accept new samples)
//   in_valid/in_ready handshake     envelope_in (u24), audio_in (s24)
//   threshold (u24), ratio_shift (2^n:1), attack_shift, release_shift, makeup_gain (Q4.12)
//   audio_out (s24, registered), gain_out (Q1.15), out_valid (1-cycle pulse)
module drc_gain_compute #(
    parameter int HOLD_SAMPLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] envelope_in,
    input  logic [23:0] audio_in,
    input  logic [23:0] threshold,
    input  logic [1:0]  ratio_shift,
    input  logic [3:0]  attack_shift,
    input  logic [3:0]  release_shift,
    input  logic [15:0] makeup_gain,
    output logic [23:0] audio_out,
    output logic [15:0] gain_out,
    output logic        out_valid
);
    localparam int DIV_CYCLES = 16;
    localparam int HW = $clog2(HOLD_SAMPLES + 2);

    typedef enum logic [2:0] {IDLE, PREP, DIV, SMOOTH, APPLY, OUT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [23:0]   env_q, env_d, aud_q, aud_d, thr_q, thr_d, rem_q, rem_d;
    logic [1:0]    rs_q, rs_d;
    logic [3:0]    atk_q, atk_d, rel_q, rel_d;
    logic [15:0]   mk_q, mk_d, sh_q, sh_d, g_q, g_d, gain_out_q, gain_out_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [23:0]   audio_out_q, audio_out_d;
    logic          bypass_q, bypass_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;

    logic [23:0]        num;
    logic [24:0]        trial, diff;
    logic [15:0]        tgt, dn, up;
    logic signed [47:0] p, y;
    logic [23:0]        y_out;

    function automatic logic [23:0] sat24(input logic signed [47:0] v);
        return (v > 48'sh7FFFFF) ? 24'h7FFFFF : (v < -48'sh800000) ? 24'h800000 : v[23:0];
    endfunction

    // Gain is Q1.15 and never exceeds 1.0, so it is always a non-negative multiplier.
    assign p = $signed({{24{aud_q[23]}}, aud_q}) * $signed({32'b0, g_q});
    assign y = p >>> 15;

`ifdef MAKEUP_GAIN_EN
    logic signed [47:0] m, y2;
    logic [23:0]        ys;
    assign ys    = sat24(y);
    assign m     = $signed({{24{ys[23]}}, ys}) * $signed({32'b0, mk_q});
    assign y2    = m >>> 12;
    assign y_out = sat24(y2);
`else
    logic unused_mk;
    assign unused_mk = ^mk_q;
    assign y_out     = sat24(y);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        env_d       = env_q;
        aud_d       = aud_q;
        thr_d       = thr_q;
        rs_d        = rs_q;
        atk_d       = atk_q;
        rel_d       = rel_q;
        mk_d        = mk_q;
        bypass_d    = bypass_q;
        rem_d       = rem_q;
        sh_d        = sh_q;
        g_d         = g_q;
        hold_d      = hold_q;
        audio_out_d = audio_out_q;
        gain_out_d  = gain_out_q;
        out_valid_d = 1'b0;
        num   = thr_q + ((env_q - thr_q) >> rs_q);
        trial = {rem_q, sh_q[15]};
        diff  = trial - {1'b0, env_q};
        tgt   = bypass_q ? 16'h8000 : sh_q;
        dn    = (g_q - tgt) >> atk_q;
        up    = (tgt - g_q) >> rel_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                env_d   = envelope_in;
                aud_d   = audio_in;
                thr_d   = threshold;
                rs_d    = ratio_shift;
                atk_d   = attack_shift;
                rel_d   = release_shift;
                mk_d    = makeup_gain;
                state_d = PREP;
            end
            PREP: begin
                // num <= env, so (num<<15)/env has no quotient bits above bit 15:
                // pre-load the remainder with num>>1 and shift in num[0] then zeros.
                bypass_d = (env_q <= thr_q) || (rs_q == 2'd0);
                rem_d    = {1'b0, num[23:1]};
                sh_d     = {num[0], 15'b0};
                cnt_d    = 4'd0;
                state_d  = DIV;
            end
            DIV: begin
                // sh_q shifts dividend bits out the top and quotient bits in the bottom.
                rem_d   = 24'((trial >= {1'b0, env_q}) ? diff : trial);
                sh_d    = {sh_q[14:0], trial >= {1'b0, env_q}};
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'(DIV_CYCLES - 1)) ? SMOOTH : DIV;
            end
            SMOOTH: begin
                // Steps are at most |t-g| and at least 1, so g cannot overshoot t.
                if (tgt < g_q) begin
                    g_d    = g_q - ((dn == 16'd0) ? 16'd1 : dn);
                    hold_d = HW'(HOLD_SAMPLES);
                end else if (hold_q != '0)
                    hold_d = hold_q - 1'b1;
                else if (tgt > g_q)
                    g_d = g_q + ((up == 16'd0) ? 16'd1 : up);
                state_d = APPLY;
            end
            APPLY: begin
                audio_out_d = y_out;
                gain_out_d  = g_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = enable && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            env_q       <= '0;
            aud_q       <= '0;
            thr_q       <= '0;
            rs_q        <= '0;
            atk_q       <= '0;
            rel_q       <= '0;
            mk_q        <= '0;
            bypass_q    <= 1'b0;
            rem_q       <= '0;
            sh_q        <= '0;
            g_q         <= 16'h8000;
            hold_q      <= '0;
            audio_out_q <= '0;
            gain_out_q  <= 16'h8000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            env_q       <= env_d;
            aud_q       <= aud_d;
            thr_q       <= thr_d;
            rs_q        <= rs_d;
            atk_q       <= atk_d;
            rel_q       <= rel_d;
            mk_q        <= mk_d;
            bypass_q    <= bypass_d;
            rem_q       <= rem_d;
            sh_q        <= sh_d;
            g_q         <= g_d;
            hold_q      <= hold_d;
            audio_out_q <= audio_out_d;
            gain_out_q  <= gain_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign audio_out = audio_out_q;
    assign gain_out  = gain_out_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_drc_gain_compute.sv
// tb_drc_gain_compute: directed self-checking bench for drc_gain_compute
module tb_drc_gain_compute;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1, in_valid = 1'b0;
    logic        in_ready, out_valid;
    logic [23:0] envelope_in = '0, audio_in = '0, threshold = '0, audio_out;
    logic [1:0]  ratio_shift = '0;
    logic [3:0]  attack_shift = '0, release_shift = '0;
    logic [15:0] makeup_gain = '0, gain_out;
    int          checks = 0, failures = 0;

    drc_gain_compute #(.HOLD_SAMPLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .envelope_in(envelope_in), .audio_in(audio_in), .threshold(threshold),
        .ratio_shift(ratio_shift), .attack_shift(attack_shift), .release_shift(release_shift),
        .makeup_gain(makeup_gain), .audio_out(audio_out), .gain_out(gain_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the out_valid pulse.
    task automatic run(input string tag, input logic [23:0] env, input logic [23:0] aud,
                       input logic [23:0] thr, input logic [1:0] rs, input logic [3:0] atk,
                       input logic [3:0] rel, input logic [15:0] mk, input logic drop_en,
                       input logic [15:0] eg, input logic [23:0] ea);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        envelope_in = env; audio_in = aud; threshold = thr; ratio_shift = rs;
        attack_shift = atk; release_shift = rel; makeup_gain = mk; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (drop_en) enable = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!out_valid && n < 40);
        check({tag, "_latency"}, 32'(n), 32'd19);
        check({tag, "_gain"}, 32'(gain_out), 32'(eg));
        check({tag, "_audio"}, 32'(audio_out), 32'(ea));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_after"}, 32'(in_ready), 32'(!drop_en));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        logic [23:0] mk_exp;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_audio", 32'(audio_out), 32'd0);
        check("rst_gain", 32'(gain_out), 32'h8000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_rst", 32'(in_ready), 32'd1);

        run("below_knee", 24'h001000, 24'h123456, 24'h100000, 2'd1, 4'd0, 4'd2, 16'h0, 1'b0, 16'h8000, 24'h123456);
        run("compress", 24'h400000, 24'h200000, 24'h100000, 2'd1, 4'd0, 4'd2, 16'h0, 1'b0, 16'h5000, 24'h140000);
        for (int i = 0; i < 4; i++)
            run("hold", 24'h001000, 24'h200000, 24'h100000, 2'd1, 4'd0, 4'd2, 16'h0, 1'b0, 16'h5000, 24'h140000);
        run("release", 24'h001000, 24'h200000, 24'h100000, 2'd1, 4'd0, 4'd2, 16'h0, 1'b0, 16'h5C00, 24'h170000);

        do_reset();
        run("negative", 24'h400000, 24'hE00000, 24'h100000, 2'd1, 4'd0, 4'd2, 16'h0, 1'b0, 16'h5000, 24'hEC0000);

        envelope_in = 24'h400000; audio_in = 24'h200000; threshold = 24'h100000; ratio_shift = 2'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_gain", 32'(gain_out), 32'h8000);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_rdy_release", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);

`ifdef MAKEUP_GAIN_EN
        mk_exp = 24'h7FFFFF;
`else
        mk_exp = 24'h600000;
`endif
        run("makeup", 24'h001000, 24'h600000, 24'h100000, 2'd1, 4'd0, 4'd2, 16'h2000, 1'b1, 16'h8000, mk_exp);
        enable = 1'b1;
        @(posedge clk); #1;
        check("reenable_ready", 32'(in_ready), 32'd1);
        run("ratio0_min", 24'h400000, 24'h800000, 24'h100000, 2'd0, 4'd0, 4'd2, 16'h1000, 1'b0, 16'h8000, 24'h800000);
        run("env_eq_thr", 24'h100000, 24'h000001, 24'h100000, 2'd2, 4'd0, 4'd2, 16'h1000, 1'b0, 16'h8000, 24'h000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
